serial_crc_gen: RTL and testbench



---
 rtl/serial_crc_pkg.sv | 16 +
 rtl/crc_lfsr_step.sv | 28 ++
 rtl/serial_crc_gen.sv | 165 ++++++++++++++++
 tb/tb_serial_crc_gen.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_crc_pkg.sv
// Shared types and constants for the serial CRC generator/checker.
package serial_crc_pkg;

    typedef enum logic {
        DATA = 1'b0,
        CRC  = 1'b1
    } state_t;

    localparam logic [4:0] CRC5_POLY = 5'h15;

    // Counter must reach MSG_LEN+WIDTH-1 (longest check-mode frame).
    function automatic int crc_cnt_width(input int msg_len, input int width);
        return $clog2(msg_len + width + 1);
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// CRC remainder register: init load, data-driven LFSR step, or zero-fill shift.
module crc_lfsr_step #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = 5'h15,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_init,
    input  logic             shift_in,
    input  logic             shift_out,
    input  logic             data_in,
    output logic [WIDTH-1:0] r
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= INIT;
        end else if (load_init) begin
            r <= INIT;
        end else if (shift_in) begin
            r <= {r[WIDTH-2:0], 1'b0} ^ ((data_in ^ r[WIDTH-1]) ? POLY : '0);
        end else if (shift_out) begin
            r <= {r[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/serial_crc_gen.sv
// Serial CRC framer: passes message bits through and appends the remainder.
// SERIAL_CRC_CHECK_EN adds a check mode that flags a nonzero received remainder.
//
// state | meaning
// DATA  | accepting message bits (plus remainder bits in check mode)
// CRC   | shifting the remainder out, input stalled
module serial_crc_gen
    import serial_crc_pkg::*;
#(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(CRC5_POLY),
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter int               MSG_LEN = 8
) (
    input  logic cgclck,
    input  logic cgrst,
    input  logic cgclr,
    input  logic cgin,
    input  logic cgin_valid,
    output logic cgin_ready,
    output logic cgout,
    output logic cgout_valid,
    output logic cglast
`ifdef SERIAL_CRC_CHECK_EN
   ,input  logic cgmode,
    output logic cgerr,
    output logic cgerr_valid
`endif
);

    localparam int CW = crc_cnt_width(MSG_LEN, WIDTH);
    localparam logic [CW-1:0] LAST_GEN = CW'(MSG_LEN - 1);
    localparam logic [CW-1:0] LAST_CHK = CW'(MSG_LEN + WIDTH - 1);
    localparam logic [CW-1:0] LAST_CRC = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, last_data;
    logic [WIDTH-1:0] r;
    logic             accept, load_init, shift_in, shift_out;
    logic             data_done, crc_done, chk_mode;

    assign last_data = chk_mode ? LAST_CHK : LAST_GEN;

    always_ff @(posedge cgclck or posedge cgrst) begin
        if (cgrst) begin
            state <= DATA;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load_init  = 1'b0;
        shift_in   = 1'b0;
        shift_out  = 1'b0;
        accept     = 1'b0;
        data_done  = 1'b0;
        crc_done   = 1'b0;
        cgin_ready = (state == DATA);
        if (cgclr) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            load_init = 1'b1;
        end else begin
            case (state)
                DATA: begin
                    if (cgin_valid) begin
                        accept   = 1'b1;
                        shift_in = 1'b1;
                        if (cnt == last_data) begin
                            data_done = 1'b1;
                            cnt_nxt   = '0;
                            // Check mode ends the frame here; no remainder to send.
                            if (chk_mode) load_init = 1'b1;
                            else          state_nxt = CRC;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                CRC: begin
                    shift_out = 1'b1;
                    if (cnt == LAST_CRC) begin
                        crc_done  = 1'b1;
                        load_init = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = DATA;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = DATA;
            endcase
        end
    end

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .clk       (cgclck),
        .rst       (cgrst),
        .load_init (load_init),
        .shift_in  (shift_in),
        .shift_out (shift_out),
        .data_in   (cgin),
        .r         (r)
    );

    always_ff @(posedge cgclck or posedge cgrst) begin
        if (cgrst) begin
            cgout       <= 1'b0;
            cgout_valid <= 1'b0;
            cglast      <= 1'b0;
        end else begin
            cgout_valid <= 1'b0;
            cglast      <= 1'b0;
            if (!cgclr) begin
                if (accept) begin
                    cgout       <= cgin;
                    cgout_valid <= 1'b1;
                    cglast      <= data_done & chk_mode;
                end else if (state == CRC) begin
                    cgout       <= r[WIDTH-1];
                    cgout_valid <= 1'b1;
                    cglast      <= crc_done;
                end
            end
        end
    end

`ifdef SERIAL_CRC_CHECK_EN
    logic             mode_q;
    logic [WIDTH-1:0] r_step;

    // Mode is live while the frame has not started, then frozen.
    assign chk_mode = (state == DATA && cnt == '0) ? cgmode : mode_q;
    assign r_step   = {r[WIDTH-2:0], 1'b0} ^ ((cgin ^ r[WIDTH-1]) ? POLY : '0);

    always_ff @(posedge cgclck or posedge cgrst) begin
        if (cgrst) begin
            mode_q      <= 1'b0;
            cgerr       <= 1'b0;
            cgerr_valid <= 1'b0;
        end else begin
            cgerr_valid <= 1'b0;
            if (state == DATA && cnt == '0) mode_q <= cgmode;
            if (data_done && chk_mode) begin
                cgerr       <= (r_step != '0);
                cgerr_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_r_low;
    assign chk_mode     = 1'b0;
    assign unused_r_low = ^r[WIDTH-2:0];
`endif

endmodule

// File: tb/tb_serial_crc_gen.sv
// Self-checking bench for serial_crc_gen; reference CRC is polynomial long division.
module tb_serial_crc_gen;

    localparam int               WIDTH   = 5;
    localparam int               MSG_LEN = 8;
    localparam int               FL      = MSG_LEN + WIDTH;
    localparam logic [WIDTH-1:0] POLY    = 5'h15;

    logic cgclck = 1'b0;
    logic cgrst, cgclr, cgin, cgin_valid;
    logic cgin_ready, cgout, cgout_valid, cglast;
`ifdef SERIAL_CRC_CHECK_EN
    logic cgmode, cgerr, cgerr_valid;
    logic err_q[$];
    logic errlast_q[$];
`endif

    int tests = 0;
    int fails = 0;

    logic out_q[$];
    logic last_q[$];
    logic vhist[$];
    logic rhist[$];

    serial_crc_gen #(
        .WIDTH   (WIDTH),
        .POLY    (POLY),
        .INIT    ('0),
        .MSG_LEN (MSG_LEN)
    ) dut (
        .cgclck      (cgclck),
        .cgrst       (cgrst),
        .cgclr       (cgclr),
        .cgin        (cgin),
        .cgin_valid  (cgin_valid),
        .cgin_ready  (cgin_ready),
        .cgout       (cgout),
        .cgout_valid (cgout_valid),
        .cglast      (cglast)
`ifdef SERIAL_CRC_CHECK_EN
       ,.cgmode      (cgmode),
        .cgerr       (cgerr),
        .cgerr_valid (cgerr_valid)
`endif
    );

    always #5 cgclck = ~cgclck;

    always @(posedge cgclck) begin
        #1;
        vhist.push_back(cgout_valid);
        rhist.push_back(cgin_ready);
        if (cgout_valid) begin
            out_q.push_back(cgout);
            last_q.push_back(cglast);
        end
`ifdef SERIAL_CRC_CHECK_EN
        if (cgerr_valid) begin
            err_q.push_back(cgerr);
            errlast_q.push_back(cglast);
        end
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void clear_mon();
        out_q.delete();
        last_q.delete();
        vhist.delete();
        rhist.delete();
`ifdef SERIAL_CRC_CHECK_EN
        err_q.delete();
        errlast_q.delete();
`endif
    endfunction

    // Remainder of msg(x)*x^WIDTH divided by x^WIDTH + POLY, by textbook long division.
    function automatic logic [WIDTH-1:0] ref_crc(input logic [1023:0] msg, input int n);
        bit a[1100];
        logic [WIDTH-1:0] rem;
        bit d;
        for (int i = 0; i < n; i++) a[i] = msg[n-1-i];
        for (int i = n; i < n + WIDTH; i++) a[i] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (a[i]) begin
                for (int j = 0; j <= WIDTH; j++) begin
                    d = (j == 0) ? 1'b1 : POLY[WIDTH-j];
                    a[i+j] = a[i+j] ^ d;
                end
            end
        end
        for (int j = 0; j < WIDTH; j++) rem[WIDTH-1-j] = a[n+j];
        return rem;
    endfunction

    function automatic logic [63:0] frame_exp(input logic [MSG_LEN-1:0] m);
        return 64'({m, ref_crc({1016'b0, m}, MSG_LEN)});
    endfunction

    function automatic logic [63:0] pack_q(input bit sel_last);
        logic [63:0] v = '0;
        for (int i = 0; i < out_q.size(); i++)
            v = {v[62:0], sel_last ? last_q[i] : out_q[i]};
        return v;
    endfunction

    function automatic int count_zeros(input bit ready_hist);
        int z = 0;
        int n = ready_hist ? rhist.size() : vhist.size();
        for (int i = 0; i < n; i++)
            if (!(ready_hist ? rhist[i] : vhist[i])) z++;
        return z;
    endfunction

    task automatic drive_bits(input logic [1023:0] bits, input int n,
                              input int gap_at, input int gap_len, input bit hold);
        int w;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge cgclck);
                    cgin_valid = 1'b0;
                end
            end
            @(negedge cgclck);
            cgin       = bits[n-1-i];
            cgin_valid = 1'b1;
            w = 0;
            while (!cgin_ready && w < 50) begin
                @(negedge cgclck);
                w++;
            end
            if (w >= 50) begin
                tests++;
                fails++;
                $display("FAIL ready_timeout: cgin_ready stayed 0 for %0d cycles, need 1", w);
            end
        end
        if (!hold) begin
            @(negedge cgclck);
            cgin_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        cgrst = 1'b1; cgclr = 1'b0; cgin = 1'b0; cgin_valid = 1'b0;
`ifdef SERIAL_CRC_CHECK_EN
        cgmode = 1'b0;
`endif
        repeat (3) @(negedge cgclck);
        cgrst = 1'b0;
        @(negedge cgclck);
        tests++; if (cgout !== 1'b0) begin fails++; $display("FAIL reset_cgout: got %b need 0", cgout); end
        tests++; if (cgout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b need 0", cgout_valid); end
        tests++; if (cglast !== 1'b0) begin fails++; $display("FAIL reset_last: got %b need 0", cglast); end
        tests++; if (cgin_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b need 1", cgin_ready); end
`ifdef SERIAL_CRC_CHECK_EN
        tests++; if ({cgerr, cgerr_valid} !== 2'b00) begin fails++; $display("FAIL reset_err: got %b need 00", {cgerr, cgerr_valid}); end
`endif
    endtask

    task automatic test_known_vector();
        logic [63:0] got, exp;
        int rz;
        clear_mon();
        drive_bits(1024'h80, MSG_LEN, -1, 0, 1'b0);
        repeat (8) @(negedge cgclck);
        got = pack_q(1'b0);
        exp = frame_exp(8'h80);
        rz  = count_zeros(1'b1);
        tests++; if (out_q.size() != FL) begin fails++; $display("FAIL kv_count: got %0d bits need %0d", out_q.size(), FL); end
        tests++; if (got !== exp) begin fails++; $display("FAIL kv_stream: got %h need %h", got, exp); end
        tests++; if (got[WIDTH-1:0] !== 5'h1C) begin fails++; $display("FAIL kv_crc: got %h need 1c", got[WIDTH-1:0]); end
        tests++; if (pack_q(1'b1) !== 64'h1) begin fails++; $display("FAIL kv_last: got %h need 1", pack_q(1'b1)); end
        tests++; if (rz != WIDTH) begin fails++; $display("FAIL kv_ready_low: got %0d cycles need %0d", rz, WIDTH); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, exp, e1, e2;
        logic [7:0]  m2;
        int run, best;
        m2 = 8'($urandom);
        clear_mon();
        drive_bits(1024'h00, MSG_LEN, -1, 0, 1'b1);
        drive_bits({1016'b0, m2}, MSG_LEN, -1, 0, 1'b0);
        repeat (8) @(negedge cgclck);
        e1 = frame_exp(8'h00);
        e2 = frame_exp(m2);
        exp = (e1 << FL) | e2;
        got = pack_q(1'b0);
        run = 0; best = 0;
        for (int i = 0; i < vhist.size(); i++) begin
            run = vhist[i] ? run + 1 : 0;
            if (run > best) best = run;
        end
        tests++; if (got !== exp) begin fails++; $display("FAIL b2b_stream: got %h need %h", got, exp); end
        tests++; if (got[FL+WIDTH-1:FL] !== 5'h00) begin fails++; $display("FAIL b2b_crc_zero: got %h need 00", got[FL+WIDTH-1:FL]); end
        tests++; if (pack_q(1'b1) !== ((64'h1 << FL) | 64'h1)) begin fails++; $display("FAIL b2b_last: got %h need %h", pack_q(1'b1), (64'h1 << FL) | 64'h1); end
        tests++; if (best != 2 * FL) begin fails++; $display("FAIL b2b_no_gap: got run %0d need %0d", best, 2 * FL); end
    endtask

    task automatic test_gap();
        logic [63:0] got;
        int first, last, z;
        clear_mon();
        drive_bits(1024'h80, MSG_LEN, 4, 3, 1'b0);
        repeat (8) @(negedge cgclck);
        got = pack_q(1'b0);
        first = -1; last = -1; z = 0;
        for (int i = 0; i < vhist.size(); i++) if (vhist[i]) begin if (first < 0) first = i; last = i; end
        for (int i = first; i <= last && first >= 0; i++) if (!vhist[i]) z++;
        tests++; if (got !== frame_exp(8'h80)) begin fails++; $display("FAIL gap_stream: got %h need %h", got, frame_exp(8'h80)); end
        tests++; if (got[WIDTH-1:0] !== 5'h1C) begin fails++; $display("FAIL gap_crc: got %h need 1c", got[WIDTH-1:0]); end
        tests++; if (z != 3) begin fails++; $display("FAIL gap_idle: got %0d idle cycles need 3", z); end
    endtask

    task automatic test_random();
        logic [7:0]  m;
        logic [63:0] got, exp;
        int ga, gl;
        for (int k = 0; k < 20; k++) begin
            m  = 8'($urandom);
            ga = $urandom_range(0, 8);
            gl = $urandom_range(0, 3);
            clear_mon();
            drive_bits({1016'b0, m}, MSG_LEN, ga, gl, 1'b0);
            repeat (8) @(negedge cgclck);
            got = pack_q(1'b0);
            exp = frame_exp(m);
            tests++; if (got !== exp) begin fails++; $display("FAIL rnd_stream[%0d] msg %h: got %h need %h", k, m, got, exp); end
            tests++; if (pack_q(1'b1) !== 64'h1) begin fails++; $display("FAIL rnd_last[%0d]: got %h need 1", k, pack_q(1'b1)); end
        end
    endtask

    task automatic test_clr();
        logic [63:0] got;
        clear_mon();
        drive_bits(1024'h80, MSG_LEN, -1, 0, 1'b0);
        repeat (2) @(negedge cgclck);
        cgclr = 1'b1;
        @(negedge cgclck);
        cgclr = 1'b0;
        tests++; if (cgout_valid !== 1'b0) begin fails++; $display("FAIL clr_valid: got %b need 0", cgout_valid); end
        tests++; if (cgin_ready !== 1'b1) begin fails++; $display("FAIL clr_ready: got %b need 1", cgin_ready); end
        tests++; if (out_q.size() != MSG_LEN + 2) begin fails++; $display("FAIL clr_partial: got %0d bits need %0d", out_q.size(), MSG_LEN + 2); end
        tests++; if (pack_q(1'b1) !== 64'h0) begin fails++; $display("FAIL clr_no_last: got %h need 0", pack_q(1'b1)); end
        clear_mon();
        drive_bits(1024'h80, MSG_LEN, -1, 0, 1'b0);
        repeat (8) @(negedge cgclck);
        got = pack_q(1'b0);
        tests++; if (got !== frame_exp(8'h80)) begin fails++; $display("FAIL clr_restart: got %h need %h", got, frame_exp(8'h80)); end
        tests++; if (got[WIDTH-1:0] !== 5'h1C) begin fails++; $display("FAIL clr_crc: got %h need 1c", got[WIDTH-1:0]); end
    endtask

    task automatic test_async_reset();
        logic [63:0] got;
        drive_bits(1024'hB, 4, -1, 0, 1'b0);
        #2 cgrst = 1'b1;
        #1;
        tests++; if ({cgout, cgout_valid, cglast} !== 3'b000) begin fails++; $display("FAIL arst_outputs: got %b need 000", {cgout, cgout_valid, cglast}); end
        #1 cgrst = 1'b0;
        #1;
        tests++; if (cgin_ready !== 1'b1) begin fails++; $display("FAIL arst_ready: got %b need 1", cgin_ready); end
        clear_mon();
        drive_bits(1024'h80, MSG_LEN, -1, 0, 1'b0);
        repeat (8) @(negedge cgclck);
        got = pack_q(1'b0);
        tests++; if (got !== frame_exp(8'h80)) begin fails++; $display("FAIL arst_next_frame: got %h need %h", got, frame_exp(8'h80)); end
        tests++; if (pack_q(1'b1) !== 64'h1) begin fails++; $display("FAIL arst_last: got %h need 1", pack_q(1'b1)); end
    endtask

`ifdef SERIAL_CRC_CHECK_EN
    task automatic test_check_mode();
        logic [FL-1:0] fr;
        logic [63:0]   got;
        for (int k = 0; k < 2; k++) begin
            fr = {8'h80, ref_crc(1024'h80, MSG_LEN)};
            if (k == 1) fr[WIDTH+3] = ~fr[WIDTH+3];
            cgmode = 1'b1;
            clear_mon();
            drive_bits({{(1024-FL){1'b0}}, fr}, FL, -1, 0, 1'b0);
            cgmode = 1'b0;
            repeat (4) @(negedge cgclck);
            got = pack_q(1'b0);
            tests++; if (got !== 64'(fr)) begin fails++; $display("FAIL chk_pass[%0d]: got %h need %h", k, got, fr); end
            tests++; if (err_q.size() != 1) begin fails++; $display("FAIL chk_err_pulses[%0d]: got %0d need 1", k, err_q.size()); end
            else begin
                tests++; if (err_q[0] !== 1'(k)) begin fails++; $display("FAIL chk_err[%0d]: got %b need %0d", k, err_q[0], k); end
                tests++; if (errlast_q[0] !== 1'b1) begin fails++; $display("FAIL chk_err_with_last[%0d]: got %b need 1", k, errlast_q[0]); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_back_to_back();
        test_gap();
        test_random();
        test_clr();
        test_async_reset();
`ifdef SERIAL_CRC_CHECK_EN
        test_check_mode();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
